// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID register.
// Keeps the PC, runs one outstanding fetch at a time to a variable-latency instruction memory,
// buffers a returned word while ID stalls, and flushes IF/ID to a NOP bubble on a redirect.
// Optional feature macro: IF_PERF_CNT_EN adds saturating fetch_cnt / bubble_cnt counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             jump_en,
  input  logic [31:0]      jump_addr,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr_id,
  output logic [31:0]      pc_id,
  output logic             valid_id
`ifdef IF_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StKill} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] instr_id_q, pc_id_q;
  logic        valid_id_q;

  // IF/ID write port: id_wr qualifies the next IF/ID contents
  logic        id_wr;
  logic [31:0] id_instr_n, id_pc_n;
  logic        id_valid_n;

  // Target alignment drops the byte offset bits
  logic unused_jump_lsb;
  assign unused_jump_lsb = ^jump_addr[1:0];

  // Request side: while killing, the old address stays on the bus until its ready
  always_comb begin
    imem_req  = (state_q == StFetch) || (state_q == StKill);
    imem_addr = (state_q == StKill) ? kill_addr_q : pc_q;
  end

  // Next-state, PC, hold buffer and IF/ID write decisions
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    id_wr       = 1'b0;
    id_instr_n  = NOP_INSTR;
    id_pc_n     = 32'h0;
    id_valid_n  = 1'b0;

    if (jump_en) begin
      // Redirect wins over stall: bubble into IF/ID, drop any buffered or returned word
      id_wr = 1'b1;
      pc_d  = {jump_addr[31:2], 2'b00};
      case (state_q)
        StFetch: begin
          if (imem_ready) begin
            state_d = StFetch;
          end else begin
            state_d     = StKill;
            kill_addr_d = pc_q;
          end
        end
        StKill:  state_d = imem_ready ? StFetch : StKill;
        default: state_d = StFetch;
      endcase
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StFetch;
          id_wr   = !stall;
        end
        StFetch: begin
          if (imem_ready) begin
            pc_d = pc_q + 32'd4;
            if (stall) begin
              buf_instr_d = imem_rdata;
              buf_pc_d    = pc_q;
              state_d     = StHold;
            end else begin
              id_wr      = 1'b1;
              id_instr_n = imem_rdata;
              id_pc_n    = pc_q;
              id_valid_n = 1'b1;
            end
          end else begin
            id_wr = !stall;
          end
        end
        StHold: begin
          if (!stall) begin
            id_wr      = 1'b1;
            id_instr_n = buf_instr_q;
            id_pc_n    = buf_pc_q;
            id_valid_n = 1'b1;
            state_d    = StFetch;
          end
        end
        StKill: begin
          // Response to the abandoned address is consumed and discarded
          if (imem_ready) state_d = StFetch;
          id_wr = !stall;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, PC, kill address and hold buffer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      kill_addr_q <= RESET_PC;
      buf_instr_q <= 32'h0;
      buf_pc_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_id_q <= NOP_INSTR;
      pc_id_q    <= 32'h0;
      valid_id_q <= 1'b0;
    end else if (id_wr) begin
      instr_id_q <= id_instr_n;
      pc_id_q    <= id_pc_n;
      valid_id_q <= id_valid_n;
    end
  end

  assign instr_id = instr_id_q;
  assign pc_id    = pc_id_q;
  assign valid_id = valid_id_q;

`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt_q, bubble_cnt_q;

  // Saturating counters of valid words and bubbles written into IF/ID
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (id_wr) begin
      if (id_valid_n && (fetch_cnt_q != {CNT_W{1'b1}})) begin
        fetch_cnt_q <= fetch_cnt_q + 1'b1;
      end
      if (!id_valid_n && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a directed vector table, then model-checked directed and random runs.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_id;
  logic [31:0] pc_id;
  logic        valid_id;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  if_fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .instr_id  (instr_id),
    .pc_id     (pc_id),
    .valid_id  (valid_id)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt (fetch_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_started;   // left the post-reset idle cycle
  logic [31:0] m_pc;
  bit          m_kill;      // an abandoned request is still outstanding
  logic [31:0] m_old;       // its address
  bit          m_buf_v;
  logic [31:0] m_buf_i, m_buf_pc;
  logic [31:0] m_instr, m_pcid;
  logic        m_valid;
  logic [31:0] m_fc, m_bc;

  task automatic model_reset();
    m_started = 0; m_pc = 32'h0; m_kill = 0; m_old = 32'h0; m_buf_v = 0;
    m_instr = NOP; m_pcid = 32'h0; m_valid = 1'b0; m_fc = 32'h0; m_bc = 32'h0;
  endtask

  function automatic bit m_req();
    return m_started && !m_buf_v;
  endfunction

  function automatic logic [31:0] m_addr();
    return m_kill ? m_old : m_pc;
  endfunction

  task automatic id_write(input logic [31:0] i, input logic [31:0] p, input logic v);
    m_instr = i; m_pcid = p; m_valid = v;
    if (v) begin
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    end else begin
      if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
    end
  endtask

  task automatic model_step(input logic s, input logic j, input logic [31:0] ja,
                            input logic r, input logic [31:0] rd);
    bit mreq, resp;
    mreq = m_req();
    resp = mreq && r;
    if (j) begin
      id_write(NOP, 32'h0, 1'b0);
      if (mreq && !resp && !m_kill) begin
        m_old  = m_pc;
        m_kill = 1;
      end else if (resp) begin
        m_kill = 0;
      end
      m_buf_v = 0; m_started = 1; m_pc = ja & 32'hFFFF_FFFC;
    end else if (!m_started) begin
      m_started = 1;
      if (!s) id_write(NOP, 32'h0, 1'b0);
    end else if (m_buf_v) begin
      if (!s) begin
        id_write(m_buf_i, m_buf_pc, 1'b1);
        m_buf_v = 0;
      end
    end else if (resp && !m_kill) begin
      if (s) begin
        m_buf_i = rd; m_buf_pc = m_pc; m_buf_v = 1;
      end else begin
        id_write(rd, m_pc, 1'b1);
      end
      m_pc = m_pc + 32'd4;
    end else begin
      if (resp) m_kill = 0;
      if (!s) id_write(NOP, 32'h0, 1'b0);
    end
  endtask

  // One model-checked cycle; entered and left at posedge+1
  task automatic drive_cycle(input logic s, input logic j, input logic [31:0] ja,
                             input logic r, input logic [31:0] rd);
    stall = s; jump_en = j; jump_addr = ja; imem_ready = r; imem_rdata = rd;
    #1;
    chk("imem_req", {31'h0, imem_req}, {31'h0, m_req()});
    chk("imem_addr", imem_addr, m_addr());
    @(posedge clk);
    model_step(s, j, ja, r, rd);
    #1;
    chk("instr_id", instr_id, m_instr);
    chk("pc_id", pc_id, m_pcid);
    chk("valid_id", {31'h0, valid_id}, {31'h0, m_valid});
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, m_fc);
    chk("bubble_cnt", bubble_cnt, m_bc);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        stall;
    logic        jump;
    logic [31:0] jaddr;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcid;
    logic        valid;
  } vec_t;

  vec_t tbl[16];

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;

    //         stall jump jaddr          rdy   req addr           instr          pcid           vld
    tbl[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        NOP,           32'h0,        1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'hA5A5_0000, 32'h0,        1'b1};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'hA5A5_0004, 32'h4,        1'b1};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        NOP,           32'h0,        1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        NOP,           32'h0,        1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,        NOP,           32'h0,        1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,        32'hA5A5_0008, 32'h8,        1'b1};
    tbl[7]  = '{1'b0, 1'b1, 32'h103,      1'b0, 1'b1, 32'hC,        NOP,           32'h0,        1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC,        NOP,           32'h0,        1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        NOP,           32'h0,        1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      32'hA5A5_0100, 32'h100,      1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      32'hA5A5_0100, 32'h100,      1'b1};
    tbl[12] = '{1'b1, 1'b1, 32'h2002,     1'b0, 1'b0, 32'h108,      NOP,           32'h0,        1'b0};
    tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2000,     32'hA5A5_2000, 32'h2000,     1'b1};
    tbl[14] = '{1'b1, 1'b1, 32'h1234_5677, 1'b1, 1'b1, 32'h2004,    NOP,           32'h0,        1'b0};
    tbl[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1234_5674, 32'hB791_5674, 32'h1234_5674, 1'b1};

    // Reset state
    #2;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr_id, NOP);
    chk("rst_pc_id", pc_id, 32'h0);
    chk("rst_valid", {31'h0, valid_id}, 32'h0);
    apply_reset();

    for (int i = 0; i < 16; i++) begin
      stall = tbl[i].stall; jump_en = tbl[i].jump; jump_addr = tbl[i].jaddr;
      imem_ready = tbl[i].ready; imem_rdata = tbl[i].addr ^ KEY;
      #1;
      chk($sformatf("tbl%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].req});
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_instr", i), instr_id, tbl[i].instr);
      chk($sformatf("tbl%0d_pc_id", i), pc_id, tbl[i].pcid);
      chk($sformatf("tbl%0d_valid", i), {31'h0, valid_id}, {31'h0, tbl[i].valid});
    end

    // Model-checked phase
    apply_reset();
    for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    // Slow memory: ready on every third request cycle
    for (int k = 0; k < 15; k++) drive_cycle(1'b0, 1'b0, 32'h0, (k % 3) == 2, $urandom);
    // Redirect with ready to the last word, then wrap
    drive_cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, $urandom);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_2222);
    chk("wrap_pc_id", pc_id, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, $urandom);

    // Reset mid-request, late ready while idle is ignored
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, $urandom);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_req", {31'h0, imem_req}, 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_valid", {31'h0, valid_id}, 32'h0);
    imem_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, $urandom);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      drive_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom,
                  $urandom_range(0, 4) < 2, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
